// File: rtl/line_clear_engine.sv
// Line-clear engine: scans a locked board bottom-up, removes full rows one per
// cycle by shifting the rows above down, and publishes the compacted board.
package game_state_pkg;
  typedef struct packed {
    logic [9:0][19:0] screen;
  } game_state_t;
endpackage

// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SCAN  | examining row ptr of the work board, clearing or stepping upward
// DONE  | one-cycle done pulse with board_out/lines_cleared freshly updated
module line_clear_engine
  import game_state_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  game_state_t board_in,
  output logic        busy,
  output logic        done,
  output game_state_t board_out,
  output logic [4:0]  lines_cleared
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  game_state_t work;
  game_state_t shifted;
  logic [4:0]  ptr;
  logic [4:0]  count;
  logic        row_full;

  always_comb begin
    row_full = 1'b1;
    for (int x = 0; x < 10; x++) begin
      row_full = row_full & work.screen[x][ptr];
    end
  end

  // Rows 0..ptr move down by one; rows below ptr keep their place.
  always_comb begin
    shifted = work;
    for (int x = 0; x < 10; x++) begin
      for (int y = 1; y < 20; y++) begin
        if (5'(y) <= ptr) begin
          shifted.screen[x][y] = work.screen[x][y-1];
        end
      end
      shifted.screen[x][0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (!row_full && (ptr == 5'd0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // ptr stays put after a clear so the row that dropped into it is re-examined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work          <= '0;
      ptr           <= 5'd19;
      count         <= 5'd0;
      board_out     <= '0;
      lines_cleared <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= board_in;
            ptr   <= 5'd19;
            count <= 5'd0;
          end
        end
        SCAN: begin
          if (row_full) begin
            work  <= shifted;
            count <= count + 5'd1;
          end else if (ptr != 5'd0) begin
            ptr <= ptr - 5'd1;
          end else begin
            board_out     <= work;
            lines_cleared <= count;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Self-checking bench for line_clear_engine: directed and random boards checked
// against a row-list compaction model, plus restart, back-to-back and reset cases.
module tb_line_clear_engine;
  import game_state_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  game_state_t board_in;
  logic        busy;
  logic        done;
  game_state_t board_out;
  logic [4:0]  lines_cleared;

  int          checks = 0;
  int          errors = 0;
  game_state_t last_out;
  logic [4:0]  last_lines;

  always #5 clk = ~clk;

  line_clear_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .board_in      (board_in),
    .busy          (busy),
    .done          (done),
    .board_out     (board_out),
    .lines_cleared (lines_cleared)
  );

  // Keep non-full rows in bottom-to-top order and restack them from the floor.
  function automatic game_state_t ref_compact(input game_state_t b, output int k);
    logic [9:0]  rows[$];
    logic [9:0]  r;
    game_state_t o;
    int          y;
    k = 0;
    o = '0;
    for (int yy = 19; yy >= 0; yy--) begin
      for (int x = 0; x < 10; x++) r[x] = b.screen[x][yy];
      if (&r) k++;
      else rows.push_back(r);
    end
    y = 19;
    foreach (rows[i]) begin
      for (int x = 0; x < 10; x++) o.screen[x][y] = rows[i][x];
      y--;
    end
    return o;
  endfunction

  function automatic game_state_t rand_board(input int full_pct);
    game_state_t b;
    logic [9:0]  r;
    b = '0;
    for (int y = 0; y < 20; y++) begin
      if (int'($urandom_range(99)) < full_pct) r = '1;
      else r = 10'($urandom) & 10'($urandom);
      for (int x = 0; x < 10; x++) b.screen[x][y] = r[x];
    end
    return b;
  endfunction

  function automatic game_state_t rand_any();
    game_state_t b;
    for (int x = 0; x < 10; x++) b.screen[x] = 20'($urandom);
    return b;
  endfunction

  function automatic game_state_t set_row(input game_state_t b, input int y);
    game_state_t o;
    o = b;
    for (int x = 0; x < 10; x++) o.screen[x][y] = 1'b1;
    return o;
  endfunction

  task automatic do_op(input game_state_t b, input int repulse_cyc, input string name);
    game_state_t exp_board;
    int          k;
    int          exp_cyc;
    int          cyc;
    bit          seen;
    exp_board = ref_compact(b, k);
    exp_cyc   = 21 + k;
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    board_in = rand_any();
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 60) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, cyc, busy);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (board_out !== last_out || lines_cleared !== last_lines) begin
          errors++;
          $display("FAIL %s outputs moved before done, cycle %0d: lines got %0d want %0d",
                   name, cyc, lines_cleared, last_lines);
        end
        @(negedge clk);
        cyc++;
        board_in = rand_any();
        start    = (cyc == repulse_cyc);
      end
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done timeout: got none want cycle %0d", name, exp_cyc);
    end else if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s done cycle: got %0d want %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (lines_cleared !== 5'(k)) begin
      errors++;
      $display("FAIL %s lines_cleared: got %0d want %0d", name, lines_cleared, k);
    end
    checks++;
    if (board_out !== exp_board) begin
      errors++;
      $display("FAIL %s board_out: got %h want %h", name, board_out, exp_board);
    end
    last_out   = exp_board;
    last_lines = 5'(k);
  endtask

  task automatic idle_hold(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start    = 1'b0;
      board_in = rand_any();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || board_out !== last_out || lines_cleared !== last_lines) begin
        errors++;
        $display("FAIL %s idle hold cycle %0d: busy=%b done=%b lines=%0d want busy=0 done=0 lines=%0d",
                 name, i, busy, done, lines_cleared, last_lines);
      end
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    board_in = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || board_out !== '0 || lines_cleared !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b lines=%0d board=%h want all zero",
               busy, done, lines_cleared, board_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    last_out   = '0;
    last_lines = 5'd0;
    idle_hold(3, "post_reset");
  endtask

  task automatic test_directed();
    game_state_t b;
    do_op('0, 0, "empty_board");
    b = set_row(set_row('0, 18), 19);
    b.screen[3][17] = 1'b1;
    do_op(b, 0, "rows_18_19_full");
    b = set_row(set_row('0, 17), 19);
    b.screen[0][18] = 1'b1;
    do_op(b, 0, "interleaved_full");
    do_op('1, 0, "all_ones");
    b = set_row('0, 0);
    b.screen[9][5] = 1'b1;
    do_op(b, 0, "full_row_0");
    idle_hold(4, "directed");
  endtask

  task automatic test_restart();
    do_op(rand_board(30), 5, "repulse_cycle5");
    idle_hold(30, "repulse_no_queue");
  endtask

  task automatic test_back_to_back();
    do_op(rand_board(25), 0, "b2b_first");
    do_op(rand_board(40), 0, "b2b_second");
    idle_hold(2, "b2b");
  endtask

  task automatic test_midscan_reset();
    game_state_t b;
    b = set_row('0, 19);
    b.screen[3][18] = 1'b1;
    do_op(b, 0, "pre_reset_op");
    @(negedge clk);
    board_in = set_row('1, 19);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || board_out !== '0 || lines_cleared !== 5'd0) begin
      errors++;
      $display("FAIL midscan_reset: busy=%b done=%b lines=%0d board=%h want all zero",
               busy, done, lines_cleared, board_out);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    last_out   = '0;
    last_lines = 5'd0;
    idle_hold(45, "after_abort");
    do_op(rand_board(35), 0, "after_abort_op");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_op(rand_board(int'($urandom_range(70))), 0, "random");
    end
    idle_hold(2, "random");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_restart();
    test_back_to_back();
    test_midscan_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
